// File: rtl/sram_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sram_block_sequencer
// Description : Single FSM that owns all SRAM traffic for DES blocks. Blocks
//               are written as WORDS_PER_BLK-word bursts into a circular ring
//               of DEPTH_BLKS slots starting at BASE_ADDR and read back in
//               FIFO order. Tracks full/empty/count, alternates fairly
//               between contending write and read requests, and delays the
//               read strobe by RD_LAT cycles to flag returning read data.
// Ports       : clk, rst            - clock / async active-high reset
//               blk_wr_req          - producer holds a block (level)
//               blk_rd_req          - consumer wants a block (level)
//               flush               - one-cycle pulse, empties the ring
//               write_enable        - SRAM write strobe
//               read_enable         - SRAM read strobe
//               address, word_idx   - SRAM word address / word in burst
//               rd_data_valid       - SRAM read data valid this cycle
//               blk_wr_done         - pulse on last written word
//               blk_rd_done         - pulse with last valid read word
//               full, empty, count  - ring occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sram_block_sequencer #(
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'h0100,
    parameter int                WORDS_PER_BLK = 4,
    parameter int                DEPTH_BLKS    = 4,
    parameter int                RD_LAT        = 1,
    localparam int               IDX_W         = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1,
    localparam int               CNT_W         = $clog2(DEPTH_BLKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_wr_req,
    input  logic              blk_rd_req,
    input  logic              flush,
    output logic              write_enable,
    output logic              read_enable,
    output logic [ADDR_W-1:0] address,
    output logic [IDX_W-1:0]  word_idx,
    output logic              rd_data_valid,
    output logic              blk_wr_done,
    output logic              blk_rd_done,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH_BLKS > 1) ? $clog2(DEPTH_BLKS) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH_BLKS - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH_BLKS);
    localparam logic [63:0]      c_LAST_ADDR = 64'(BASE_ADDR)
                                             + 64'(DEPTH_BLKS) * 64'(WORDS_PER_BLK) - 64'd1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WR_BURST = 2'd1;
    localparam logic [1:0] c_RD_BURST = 2'd2;
    localparam logic [1:0] c_RD_DRAIN = 2'd3;

    // The whole ring must be addressable.
    generate
        if ((c_LAST_ADDR >> ADDR_W) != 64'd0) begin : g_addr_range_err
            $error("sram_block_sequencer: ring does not fit in ADDR_W address bits");
        end
    endgenerate

    logic [1:0]        r_state,       w_state_nxt;
    logic              r_we,          w_we_nxt;
    logic              r_re,          w_re_nxt;
    logic [ADDR_W-1:0] r_addr,        w_addr_nxt;
    logic [IDX_W-1:0]  r_idx,         w_idx_nxt;
    logic              r_wr_done,     w_wr_done_nxt;
    logic [PTR_W-1:0]  r_wr_ptr,      w_wr_ptr_nxt;
    logic [PTR_W-1:0]  r_rd_ptr,      w_rd_ptr_nxt;
    logic [CNT_W-1:0]  r_count,       w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_last_rd,     w_last_rd_nxt;     // 1: last served was a read
    logic              r_flush_pend,  w_flush_pend_nxt;
    logic [RD_LAT-1:0] r_rv_pipe;                        // read strobe delay line
    logic [RD_LAT-1:0] r_last_pipe;                      // marks the final word of a burst

    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_serve_wr;
    logic              w_serve_rd;
    logic [ADDR_W-1:0] w_wr_base;
    logic [ADDR_W-1:0] w_rd_base;
    logic [PTR_W-1:0]  w_wr_ptr_inc;
    logic [PTR_W-1:0]  w_rd_ptr_inc;
    logic              w_rd_done;

    assign w_wr_elig  = blk_wr_req && !r_full;
    assign w_rd_elig  = blk_rd_req && !r_empty;
    // On contention, serve whichever direction was not served last.
    assign w_serve_wr = w_wr_elig && (!w_rd_elig || r_last_rd);
    assign w_serve_rd = w_rd_elig && !w_serve_wr;

    assign w_wr_base = BASE_ADDR + ADDR_W'(WORDS_PER_BLK) * ADDR_W'(r_wr_ptr);
    assign w_rd_base = BASE_ADDR + ADDR_W'(WORDS_PER_BLK) * ADDR_W'(r_rd_ptr);

    assign w_wr_ptr_inc = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

    assign w_rd_done = r_last_pipe[RD_LAT-1];

    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = 1'b0;
        w_re_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_idx_nxt        = r_idx;
        w_wr_done_nxt    = 1'b0;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_count_nxt      = r_count;
        w_last_rd_nxt    = r_last_rd;
        w_flush_pend_nxt = r_flush_pend | flush;

        case (r_state)
            c_IDLE: begin
                w_flush_pend_nxt = 1'b0;
                if (r_flush_pend || flush) begin
                    // A flush replaces arbitration for this cycle.
                    w_wr_ptr_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_count_nxt  = '0;
                end else if (w_serve_wr) begin
                    w_state_nxt   = c_WR_BURST;
                    w_we_nxt      = 1'b1;
                    w_addr_nxt    = w_wr_base;
                    w_idx_nxt     = '0;
                    w_wr_done_nxt = (c_LAST_IDX == '0);
                    w_last_rd_nxt = 1'b0;
                end else if (w_serve_rd) begin
                    w_state_nxt   = c_RD_BURST;
                    w_re_nxt      = 1'b1;
                    w_addr_nxt    = w_rd_base;
                    w_idx_nxt     = '0;
                    w_last_rd_nxt = 1'b1;
                end
            end
            c_WR_BURST: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt  = c_IDLE;
                    w_wr_ptr_nxt = w_wr_ptr_inc;
                    w_count_nxt  = r_count + CNT_W'(1);
                end else begin
                    w_we_nxt      = 1'b1;
                    w_idx_nxt     = r_idx + IDX_W'(1);
                    w_addr_nxt    = r_addr + ADDR_W'(1);
                    w_wr_done_nxt = ((r_idx + IDX_W'(1)) == c_LAST_IDX);
                end
            end
            c_RD_BURST: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = c_RD_DRAIN;
                end else begin
                    w_re_nxt   = 1'b1;
                    w_idx_nxt  = r_idx + IDX_W'(1);
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            c_RD_DRAIN: begin
                // Leave once the final word's data has been flagged valid.
                if (w_rd_done) begin
                    w_state_nxt  = c_IDLE;
                    w_rd_ptr_nxt = w_rd_ptr_inc;
                    w_count_nxt  = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_idx        <= '0;
            r_wr_done    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_last_rd    <= 1'b1;
            r_flush_pend <= 1'b0;
            r_rv_pipe    <= '0;
            r_last_pipe  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_re         <= w_re_nxt;
            r_addr       <= w_addr_nxt;
            r_idx        <= w_idx_nxt;
            r_wr_done    <= w_wr_done_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_full       <= (w_count_nxt == c_DEPTH);
            r_empty      <= (w_count_nxt == '0);
            r_last_rd    <= w_last_rd_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_rv_pipe[0]   <= r_re;
            r_last_pipe[0] <= r_re && (r_idx == c_LAST_IDX);
            for (int i = 1; i < RD_LAT; i++) begin
                r_rv_pipe[i]   <= r_rv_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    assign write_enable  = r_we;
    assign read_enable   = r_re;
    assign address       = r_addr;
    assign word_idx      = r_idx;
    assign rd_data_valid = r_rv_pipe[RD_LAT-1];
    assign blk_wr_done   = r_wr_done;
    assign blk_rd_done   = w_rd_done;
    assign full          = r_full;
    assign empty         = r_empty;
    assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sram_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_block_sequencer
// Description : Self-checking bench for sram_block_sequencer. A default
//               instance runs a cycle table plus hand-written sequences for
//               fill/wrap, contention, flush and reset; a second instance
//               with RD_LAT=3 checks the read-valid delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_block_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0, rd_req = 1'b0, flush = 1'b0;
    logic        we, re, rv, wd, rdn, full, empty;
    logic [15:0] addr;
    logic [1:0]  idx;
    logic [2:0]  cnt;

    logic        wr3 = 1'b0, rd3 = 1'b0;
    logic        we3, re3, rv3, wd3, rdn3, full3, empty3;
    logic [15:0] addr3;
    logic [1:0]  idx3;
    logic [2:0]  cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_block_sequencer dut (
        .clk(clk), .rst(rst), .blk_wr_req(wr_req), .blk_rd_req(rd_req), .flush(flush),
        .write_enable(we), .read_enable(re), .address(addr), .word_idx(idx),
        .rd_data_valid(rv), .blk_wr_done(wd), .blk_rd_done(rdn),
        .full(full), .empty(empty), .count(cnt)
    );

    sram_block_sequencer #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .blk_wr_req(wr3), .blk_rd_req(rd3), .flush(1'b0),
        .write_enable(we3), .read_enable(re3), .address(addr3), .word_idx(idx3),
        .rd_data_valid(rv3), .blk_wr_done(wd3), .blk_rd_done(rdn3),
        .full(full3), .empty(empty3), .count(cnt3)
    );

    typedef struct {
        logic        wr, rd, fl;
        logic        we, re, rv, wd, rdn;
        logic [2:0]  cnt;
        logic        full, empty;
        logic        chk_a;
        logic [15:0] addr;
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic wr_block(input logic [15:0] base);
        wr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wr_word", {we, re, wd, addr, 6'(idx)},
                {1'b1, 1'b0, (k == 3), base + 16'(k), 6'(k)});
            if (k == 3) wr_req = 1'b0;
        end
        @(negedge clk);
        chk("wr_after", {29'd0, we}, 32'd0);
    endtask

    task automatic rd_block(input logic [15:0] base);
        rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rd_word", {re, we, rv, rdn, addr, 6'(idx)},
                {1'b1, 1'b0, (k != 0), 1'b0, base + 16'(k), 6'(k)});
        end
        @(negedge clk);
        chk("rd_last_valid", {29'd0, re, rv, rdn}, {29'd0, 3'b011});
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_after", {30'd0, rv, re}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;
        int         nb;
        logic       pw, pr;

        //           wr rd fl we re rv wd rdn cnt full emp chk addr      idx
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 16'h0100, 2'd0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 1, 0, 16'h0100, 2'd0};
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 1, 0, 16'h0101, 2'd1};
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 1, 0, 16'h0102, 2'd2};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 1, 0, 3'd0, 0, 1, 0, 16'h0103, 2'd3};
        vecs[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 16'h0000, 2'd0};
        vecs[6]  = '{0, 1, 0, 0, 1, 0, 0, 0, 3'd1, 0, 0, 0, 16'h0100, 2'd0};
        vecs[7]  = '{0, 1, 0, 0, 1, 1, 0, 0, 3'd1, 0, 0, 0, 16'h0101, 2'd1};
        vecs[8]  = '{0, 1, 0, 0, 1, 1, 0, 0, 3'd1, 0, 0, 0, 16'h0102, 2'd2};
        vecs[9]  = '{0, 1, 0, 0, 1, 1, 0, 0, 3'd1, 0, 0, 0, 16'h0103, 2'd3};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 3'd1, 0, 0, 0, 16'h0000, 2'd0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 16'h0000, 2'd0};

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Write then read, one row per cycle.
        for (int i = 0; i < 12; i++) begin
            logic        show_a;
            logic [27:0] act, exp;
            show_a = vecs[i].chk_a || vecs[i].we || vecs[i].re;
            act = {show_a ? addr : 16'h0, show_a ? idx : 2'd0,
                   we, re, rv, wd, rdn, full, empty, cnt};
            exp = {show_a ? vecs[i].addr : 16'h0, show_a ? vecs[i].idx : 2'd0,
                   vecs[i].we, vecs[i].re, vecs[i].rv, vecs[i].wd, vecs[i].rdn,
                   vecs[i].full, vecs[i].empty, vecs[i].cnt};
            chk($sformatf("table_row%0d", i), 32'(act), 32'(exp));
            wr_req = vecs[i].wr;
            rd_req = vecs[i].rd;
            flush  = vecs[i].fl;
            @(negedge clk);
        end

        // Flush in IDLE rewinds the pointers (ring is at slot 1 here).
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {30'd0, empty, full}, {30'd0, 2'b10});

        // Fill and wrap.
        wr_block(16'h0100);
        wr_block(16'h0104);
        wr_block(16'h0108);
        wr_block(16'h010C);
        chk("fill_full", {28'd0, full, cnt}, {28'd0, 1'b1, 3'd4});
        wr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_no_strobe", {30'd0, we, re}, 32'd0);
        end
        wr_req = 1'b0;
        rd_block(16'h0100);
        chk("after_read_cnt", {28'd0, full, cnt}, {28'd0, 1'b0, 3'd3});
        wr_block(16'h0100);
        chk("wrap_full", {28'd0, full, cnt}, {28'd0, 1'b1, 3'd4});

        // Contention from reset: W, R, W, R.
        do_reset();
        wr_req = 1'b1;
        rd_req = 1'b1;
        seq = '0;
        nb  = 0;
        pw  = 1'b0;
        pr  = 1'b0;
        for (int c = 0; c < 80 && nb < 4; c++) begin
            @(negedge clk);
            if (we && !pw) begin seq[nb] = 1'b0; nb++; end
            else if (re && !pr) begin seq[nb] = 1'b1; nb++; end
            pw = we;
            pr = re;
        end
        chk("contention_bursts", 32'(nb), 32'd4);
        chk("contention_order", {28'd0, seq}, {28'd0, 4'b1010});
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (12) @(negedge clk);

        // Flush mid-write: burst completes, then ring empties.
        do_reset();
        wr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flushwr_word", {we, wd, 14'd0, addr}, {1'b1, (k == 3), 14'd0, 16'h0100 + 16'(k)});
            if (k == 1) flush = 1'b1;
            if (k == 2) flush = 1'b0;
            if (k == 3) wr_req = 1'b0;
        end
        @(negedge clk);
        chk("flushwr_cnt_upd", {29'd0, cnt}, 32'd1);
        @(negedge clk);
        chk("flushwr_empty", {28'd0, empty, cnt}, {28'd0, 1'b1, 3'd0});

        // Asynchronous reset in the middle of a read burst.
        wr_block(16'h0100);
        rd_req = 1'b1;
        @(negedge clk);
        chk("rstrd_w0", {15'd0, re, addr}, {15'd0, 1'b1, 16'h0100});
        @(negedge clk);
        chk("rstrd_w1", {14'd0, re, rv, addr}, {14'd0, 2'b11, 16'h0101});
        rst = 1'b1;
        #1;
        chk("rst_mid_read", {10'd0, re, rv, empty, cnt, addr}, {10'd0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0100});
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // RD_LAT=3 instance.
        wr3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat3_wr", {15'd0, we3, addr3}, {15'd0, 1'b1, 16'h0100 + 16'(k)});
            if (k == 3) wr3 = 1'b0;
        end
        @(negedge clk);
        rd3 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("lat3_cyc%0d", c), {26'd0, re3, rv3, rdn3, cnt3},
                {26'd0, (c <= 4), (c >= 4 && c <= 7), (c == 7), (c >= 8) ? 3'd0 : 3'd1});
            if (c == 7) rd3 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
